// File: rtl/itlb.sv
// itlb -- fully-associative instruction TLB for the fetch stage.
//
// Translates the fetch VA to a PA combinationally when an entry matches. On a
// miss the fetch stage is stalled, one request is sent to the page table
// walker, and the response fills the round-robin victim entry.
//
// Optional feature macro: ITLB_PERF_CNT_EN
//   defined   -> F_itlb_hits / F_itlb_misses are saturating 16-bit counters
//   undefined -> both outputs are tied to zero and no counter flops exist
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   F_va_valid/F_va  fetch VA presented this cycle
//   F_itlb_flush     invalidate all entries
//   F_pa             {PPN, offset}, zero unless F_itlb_hit
//   F_itlb_hit       lookup hit (only in IDLE)
//   F_itlb_stall     fetch must hold (valid VA without a hit)
//   Itlb_pa_request  one-cycle registered request pulse to the PTW
//   Itlb_va          miss VA, stable from request until response
//   F_ptw_valid      one-cycle PTW response pulse
//   F_ptw_pa         PPN returned for Itlb_va
//   F_itlb_hits      hit counter
//   F_itlb_misses    miss counter
//   dbg_state_o      current FSM state (0 IDLE, 1 REQ, 2 WAIT)
//
// PTW handshake: there is no ready/backpressure. Itlb_pa_request is a single
// cycle pulse; Itlb_va is held until the walker answers with a single-cycle
// F_ptw_valid pulse while the FSM is in WAIT. A walk cannot be cancelled, so a
// flush during a walk only marks the eventual response to be dropped.
module itlb #(
  parameter int VA_WIDTH    = 20,
  parameter int OFFSET_BITS = 12,
  parameter int PPN_WIDTH   = 8,
  parameter int ENTRIES     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             F_va_valid,
  input  logic [VA_WIDTH-1:0]              F_va,
  input  logic                             F_itlb_flush,
  output logic [PPN_WIDTH+OFFSET_BITS-1:0] F_pa,
  output logic                             F_itlb_hit,
  output logic                             F_itlb_stall,
  output logic                             Itlb_pa_request,
  output logic [VA_WIDTH-1:0]              Itlb_va,
  input  logic                             F_ptw_valid,
  input  logic [PPN_WIDTH-1:0]             F_ptw_pa,
  output logic [15:0]                      F_itlb_hits,
  output logic [15:0]                      F_itlb_misses,
  output logic [1:0]                       dbg_state_o
);

  localparam int VPN_W = VA_WIDTH - OFFSET_BITS;
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e               state_q;
  logic [ENTRIES-1:0]   valid_q;
  logic [VPN_W-1:0]     vpn_q [ENTRIES];
  logic [PPN_WIDTH-1:0] ppn_q [ENTRIES];
  logic [IDX_W-1:0]     victim_q;
  logic                 drop_q;
  logic                 req_q;
  logic [VA_WIDTH-1:0]  va_q;

  logic [VPN_W-1:0]     f_vpn;
  logic                 match_any;
  logic [PPN_WIDTH-1:0] match_ppn;
  logic                 miss;
  logic                 fill_en;

  assign f_vpn = F_va[VA_WIDTH-1:OFFSET_BITS];

  // Parallel lookup; scanning from the top down lets the lowest matching
  // index win should duplicates ever exist.
  always_comb begin
    match_any = 1'b0;
    match_ppn = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (vpn_q[i] == f_vpn)) begin
        match_any = 1'b1;
        match_ppn = ppn_q[i];
      end
    end
  end

  assign F_itlb_hit   = F_va_valid && (state_q == S_IDLE) && match_any;
  assign F_itlb_stall = F_va_valid && !F_itlb_hit;
  assign F_pa         = F_itlb_hit ? {match_ppn, F_va[OFFSET_BITS-1:0]} : '0;
  assign miss         = F_va_valid && (state_q == S_IDLE) && !match_any;

  // A response coinciding with a flush, or arriving after a flush during the
  // walk, is discarded and does not advance the victim pointer.
  assign fill_en = !rst && (state_q == S_WAIT) && F_ptw_valid && !drop_q && !F_itlb_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      valid_q  <= '0;
      victim_q <= '0;
      drop_q   <= 1'b0;
      req_q    <= 1'b0;
      va_q     <= '0;
    end else begin
      req_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (miss) begin
            va_q    <= F_va;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: state_q <= S_WAIT;
        S_WAIT: begin
          if (F_ptw_valid) begin
            state_q <= S_IDLE;
            drop_q  <= 1'b0;
            if (fill_en) begin
              valid_q[victim_q] <= 1'b1;
              victim_q          <= victim_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (F_itlb_flush) begin
        valid_q <= '0;
        // Mark an in-flight walk as stale unless it completes this very cycle.
        if ((state_q != S_IDLE) && !((state_q == S_WAIT) && F_ptw_valid)) begin
          drop_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      vpn_q[victim_q] <= va_q[VA_WIDTH-1:OFFSET_BITS];
      ppn_q[victim_q] <= F_ptw_pa;
    end
  end

  assign Itlb_pa_request = req_q;
  assign Itlb_va         = va_q;
  assign dbg_state_o     = state_q;

`ifdef ITLB_PERF_CNT_EN
  logic [15:0] hits_q, hits_d;
  logic [15:0] misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (F_itlb_hit && (hits_q != 16'hFFFF)) begin
      hits_d = hits_q + 16'd1;
    end
    if (miss && (misses_q != 16'hFFFF)) begin
      misses_d = misses_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign F_itlb_hits   = hits_q;
  assign F_itlb_misses = misses_q;
`else
  assign F_itlb_hits   = '0;
  assign F_itlb_misses = '0;
`endif

endmodule
